// File: rtl/ysyx_23060208_clint_slave_if.sv
// AXI4-Lite read channel bundle between the data crossbar and the CLINT.
interface ysyx_23060208_clint_slave_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] araddr_i;
    logic                  arvalid_i;
    logic                  arready_o;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic [1:0]            rresp_o;
    logic                  rvalid_o;
    logic                  rready_i;

    modport master (
        output araddr_i, arvalid_i, rready_i,
        input  arready_o, rdata_o, rresp_o, rvalid_o
    );

    modport slave (
        input  araddr_i, arvalid_i, rready_i,
        output arready_o, rdata_o, rresp_o, rvalid_o
    );
endinterface

// File: rtl/ysyx_23060208_clint_slave.sv
// CLINT mtime responder: free-running 64-bit timer read as two 32-bit words,
// with the high word latched on the low read so the pair is coherent.
module ysyx_23060208_clint_slave #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'ha000_0048,
    parameter logic [63:0]           MTIME_INIT = 64'h0,
    parameter int unsigned           TICK_DIV   = 1
) (
    input  logic clk,
    input  logic rst,
    ysyx_23060208_clint_slave_if.slave bus
);
    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [ADDR_WIDTH-1:0] HI_ADDR = BASE_ADDR + ADDR_WIDTH'(4);
    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    state_t           state;
    logic [63:0]      mtime;
    logic [PRE_W-1:0] prescaler;
    logic [31:0]      shadow_hi;
    logic             shadow_vld;
    logic             tick_c;

    assign tick_c = (prescaler == PRE_W'(TICK_DIV - 1));

    // Free-running timebase; never stalls for bus activity
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime     <= MTIME_INIT;
            prescaler <= '0;
        end else if (tick_c) begin
            mtime     <= mtime + 64'd1;
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PRE_W'(1);
        end
    end

    // Read handshake FSM; response captured from pre-increment mtime on the AR edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            bus.arready_o <= 1'b1;
            bus.rvalid_o  <= 1'b0;
            bus.rdata_o   <= '0;
            bus.rresp_o   <= RRESP_OKAY;
            shadow_hi     <= '0;
            shadow_vld    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.arvalid_i) begin
                        state         <= RESP;
                        bus.arready_o <= 1'b0;
                        bus.rvalid_o  <= 1'b1;
                        if (bus.araddr_i == BASE_ADDR) begin
                            bus.rdata_o <= DATA_WIDTH'(mtime[31:0]);
                            bus.rresp_o <= RRESP_OKAY;
                            shadow_hi   <= mtime[63:32];
                            shadow_vld  <= 1'b1;
                        end else if (bus.araddr_i == HI_ADDR) begin
                            bus.rdata_o <= shadow_vld ? DATA_WIDTH'(shadow_hi)
                                                      : DATA_WIDTH'(mtime[63:32]);
                            bus.rresp_o <= RRESP_OKAY;
                            shadow_vld  <= 1'b0;
                        end else begin
                            bus.rdata_o <= '0;
                            bus.rresp_o <= RRESP_SLVERR;
                        end
                    end
                end
                RESP: begin
                    if (bus.rready_i) begin
                        state         <= IDLE;
                        bus.arready_o <= 1'b1;
                        bus.rvalid_o  <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/ysyx_23060208_clint_slave.md
Name: ysyx_23060208_clint_slave

Overview:
- AXI4-Lite read-only responder for the core-local timer (CLINT).
- Sits on the slave side of the data-memory crossbar; the arbiter forwards EXU loads addressed to BASE_ADDR or BASE_ADDR+4 here.
- Keeps a free-running 64-bit mtime counter and returns a coherent 64-bit value across the two 32-bit reads (low word, then high word).

Parameters:
- ADDR_WIDTH, 32, address bus width.
- DATA_WIDTH, 32, read data width. Only 32 is supported.
- BASE_ADDR, 32'ha000_0048, address of the mtime low word. The high word is at BASE_ADDR+4.
- MTIME_INIT, 64'h0, reset value of mtime.
- TICK_DIV, 1, clock cycles per mtime increment. Must be >= 1.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  reset, asynchronous, active-low.
- araddr_i  in  ADDR_WIDTH  read address from master.
- arvalid_i  in  1  read address valid.
- arready_o  out  1  read address ready.
- rdata_o  out  DATA_WIDTH  read data.
- rresp_o  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR.
- rvalid_o  out  1  read data valid.
- rready_i  in  1  master ready for read data.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low. While rst=0:
  - state=IDLE, mtime=MTIME_INIT, prescaler=0, shadow_hi=0, shadow_vld=0.
  - rvalid_o=0, rdata_o=0, rresp_o=0, arready_o=1.
  - Reset asserted in the middle of a transaction clears rvalid_o immediately. The pending response is discarded.
- Prescaler:
  - Counts 0..TICK_DIV-1 on every clk edge.
  - mtime increments by 1 on the edge where the prescaler equals TICK_DIV-1; the prescaler then returns to 0.
  - With TICK_DIV=1, mtime increments on every edge.
  - mtime wraps from 64'hFFFF_FFFF_FFFF_FFFF to 0 with no flag.
  - The counter never stalls, including during reads and backpressure.
- State machine, two states:
  - IDLE: arready_o=1, rvalid_o=0. When arvalid_i=1 the address is accepted on that edge and the next state is RESP.
  - RESP: arready_o=0, rvalid_o=1. rdata_o and rresp_o are held stable. When rready_i=1 the response completes on that edge and the next state is IDLE.
- Handshake rules:
  - arready_o is a function of state only and never depends on arvalid_i.
  - At most one outstanding transaction.
  - Latency: rvalid_o rises on the first cycle after the AR handshake edge.
  - Back-to-back throughput is one transaction per 2 cycles minimum.
- Sampling: the value returned is mtime as it was before the update on the AR handshake edge (pre-increment value).
- Address decode, full ADDR_WIDTH compare:
  - araddr_i==BASE_ADDR: rdata = mtime[31:0], rresp=00. Also shadow_hi <= mtime[63:32] and shadow_vld <= 1, both taken from the same sampled value.
  - araddr_i==BASE_ADDR+4, shadow_vld=1: rdata = shadow_hi, rresp=00, then shadow_vld <= 0.
  - araddr_i==BASE_ADDR+4, shadow_vld=0: rdata = mtime[63:32] (live), rresp=00.
  - Any other address: rdata=0, rresp=2'b10. Shadow state is unchanged.
- Boundary cases:
  - Two consecutive low reads: the second one overwrites the shadow.
  - A high read after a bad-address read still uses the shadow if shadow_vld=1.
  - arvalid_i asserted while in RESP is ignored until the state returns to IDLE. The master must hold arvalid_i per AXI rules.

Test Plan:
- Single read after reset (TICK_DIV=1, MTIME_INIT=0): release rst, hold araddr=0xa000_0048 with arvalid=1, handshake on the 10th posedge → next cycle rvalid=1, rdata=32'd9, rresp=00.
- Backpressure: hold rready=0 for 5 cycles after rvalid rises → rvalid stays 1, rdata stays constant, arready=0 for all 5 cycles. Completes on the rready=1 edge, then arready=1.
- Hi/lo coherency (MTIME_INIT=64'h0000_0000_FFFF_FFFE): low read sampled at 0x0000_0000_FFFF_FFFF returns 0xFFFF_FFFF. High read 3 cycles later returns 0x0000_0000 (shadow), not 0x0000_0001. An immediately following second high read returns live 0x0000_0001.
- Bad address: araddr=0xa000_0050 → rresp=2'b10, rdata=0. mtime keeps counting. A subsequent BASE+4 read still returns the old shadow.
- Prescaler and wrap (TICK_DIV=4, MTIME_INIT=64'hFFFF_FFFF_FFFF_FFFF): low read after 8 post-reset edges returns 1. mtime reads FFFF_FFFF / FFFF_FFFF before the 4th edge, then 0 / 0.
- Async reset mid-response: drop rst while rvalid=1 and rready=0 → rvalid goes to 0 without waiting for clk, mtime=MTIME_INIT. After release, a BASE+4 read returns the live high word (shadow cleared).
